// File: rtl/ahbl_bus_mux.sv
// AHB-Lite page decoder / response mux for NS slaves, with a built-in default slave
// that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR. Optional watchdog: AHBL_BUS_TIMEOUT_EN.
module ahbl_bus_mux #(
  parameter int                     NS         = 7,
  parameter int                     PAGE_W     = 8,
  parameter int                     PAGE_LSB   = 24,
  parameter logic [NS*PAGE_W-1:0]   SLV_PAGES  = {8'h40, 8'h4B, 8'h4A, 8'h49, 8'h48, 8'h20, 8'h00},
  parameter logic [31:0]            DFLT_RDATA = 32'hDEADBEEF,
  parameter int                     TIMEOUT    = 256
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic [31:0]      HRDATA,
  output logic             HREADY,
  output logic             HRESP,
  output logic [NS-1:0]    HSEL,
  input  logic [NS-1:0]    HREADY_S,
  input  logic [NS-1:0]    HRESP_S,
  input  logic [NS*32-1:0] HRDATA_S,
  output logic             TO_FLAG,
  output logic [3:0]       TO_IDX
);

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  ds_state_e         state_q, state_d;
  logic [NS-1:0]     dsel_q, dsel_d;
  logic [PAGE_W-1:0] page;
  logic [NS-1:0]     hsel;
  logic              unmapped;
  logic              s_ready, s_resp;
  logic [31:0]       s_rdata;
  logic [3:0]        s_idx;

  // Address-phase decode; scanning from the top down lets the lowest matching index win.
  always_comb begin
    page = HADDR[PAGE_LSB +: PAGE_W];
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hsel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (page == SLV_PAGES[i*PAGE_W +: PAGE_W]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign unmapped = ~|hsel;
  assign HSEL     = hsel;

  // Data-phase slave mux; dsel_q is one-hot or zero, so a plain scan is a true mux.
  always_comb begin
    s_ready = 1'b1;
    s_resp  = 1'b0;
    s_rdata = DFLT_RDATA;
    s_idx   = '0;
    for (int i = 0; i < NS; i++) begin
      if (dsel_q[i]) begin
        s_ready = HREADY_S[i];
        s_resp  = HRESP_S[i];
        s_rdata = HRDATA_S[i*32 +: 32];
        s_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    unique case (state_q)
      DS_ERR1: begin HREADY = 1'b0;    HRESP = 1'b1;   HRDATA = DFLT_RDATA; end
      DS_ERR2: begin HREADY = 1'b1;    HRESP = 1'b1;   HRDATA = DFLT_RDATA; end
      default: begin HREADY = s_ready; HRESP = s_resp; HRDATA = s_rdata;    end
    endcase
  end

`ifdef AHBL_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_flag_q, to_flag_d;
  logic [3:0]       to_idx_q, to_idx_d;
`endif

  always_comb begin
    dsel_d  = dsel_q;
    state_d = state_q;
    if (state_q == DS_ERR1) begin
      state_d = DS_ERR2;
    end else if (HREADY) begin
      dsel_d  = hsel;
      state_d = (unmapped && HTRANS[1]) ? DS_ERR1 : DS_IDLE;
    end
`ifdef AHBL_BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_flag_d = to_flag_q;
    to_idx_d  = to_idx_q;
    if (HREADY) begin
      cnt_d = '0;
    end else if (dsel_q != '0) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        // Abandon the stalled slave and let the default slave finish the transfer.
        state_d = DS_ERR1;
        dsel_d  = '0;
        cnt_d   = '0;
        if (!to_flag_q) begin
          to_flag_d = 1'b1;
          to_idx_d  = s_idx;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_IDLE;
      dsel_q  <= '0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
    end
  end

`ifdef AHBL_BUS_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
      to_idx_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      to_flag_q <= to_flag_d;
      to_idx_q  <= to_idx_d;
    end
  end

  assign TO_FLAG = to_flag_q;
  assign TO_IDX  = to_idx_q;
`else
  assign TO_FLAG = 1'b0;
  assign TO_IDX  = 4'd0;
`endif

  // Only the page field and HTRANS[1] matter to the decoder.
  logic unused_ok;
  assign unused_ok = ^{HADDR, HTRANS[0], 32'(TIMEOUT)};

endmodule
